// File: rtl/alu_pkg.sv
// Shared types for the ALU command sequencer: opcode and FSM state enums,
// counter width, and the packed width of one command FIFO entry.
package alu_pkg;

  typedef enum logic [2:0] {
    ADD = 3'd0,
    SUB = 3'd1,
    DEC = 3'd2,
    INC = 3'd3,
    NOT = 3'd4,
    AND = 3'd5,
    OR  = 3'd6,
    XOR = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } seq_state_e;

  localparam int OVF_CNT_W = 8;
  localparam int OPCODE_W  = 3;

  // Entry layout is {chain?, opcode, a, b}; the chain bit exists only when chaining is built in.
  function automatic int cmd_entry_w(input int n, input bit with_chain);
    return OPCODE_W + 2 * n + (with_chain ? 1 : 0);
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command FIFO for the ALU sequencer: registered storage, combinational head
// read, synchronous active-high reset. A push into a full FIFO is dropped even
// if a pop happens in the same cycle (no bypass path).
module alu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage write; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is a power of 2).
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Initiator side of the combinational ALU interface. Commands are queued in a
// small FIFO, issued to the external ALU, the result is captured after one
// settle cycle and returned on a valid/ready response stream.
// Optional build macro: ALU_CHAIN_EN -- a command flagged cmd_chain takes its
// A operand from the most recently captured result.
//
// state | meaning
// IDLE  | nothing in flight; pop the FIFO head as soon as one exists
// ISSUE | ALU inputs held for one cycle; result captured at the end of it
// RESP  | rsp_* valid and frozen until the consumer accepts
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int N          = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [2:0]           cmd_opcode,
  input  logic [N-1:0]         cmd_a,
  input  logic [N-1:0]         cmd_b,
  input  logic                 cmd_chain,
  output logic [N-1:0]         alu_a,
  output logic [N-1:0]         alu_b,
  output logic [2:0]           alu_opcode,
  input  logic [N-1:0]         alu_y,
  input  logic                 alu_overflow,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [N-1:0]         rsp_y,
  output logic                 rsp_overflow,
  output logic [2:0]           rsp_opcode,
  output logic [OVF_CNT_W-1:0] ovf_count
);

`ifdef ALU_CHAIN_EN
  localparam int ENTRY_W = cmd_entry_w(N, 1'b1);
`else
  localparam int ENTRY_W = cmd_entry_w(N, 1'b0);
`endif

  logic [ENTRY_W-1:0] push_data;
  logic [ENTRY_W-1:0] head;
  logic               fifo_full;
  logic               fifo_empty;
  logic               push;
  logic               pop;
  logic [2:0]         head_op;
  logic [N-1:0]       head_a;
  logic [N-1:0]       head_b;
  logic [N-1:0]       head_a_eff;
  seq_state_e         state;

  assign cmd_ready = !rst && !fifo_full;
  assign push      = cmd_valid && cmd_ready;
  assign pop       = !fifo_empty && ((state == IDLE) || ((state == RESP) && rsp_ready));

`ifdef ALU_CHAIN_EN
  logic head_chain;
  assign push_data = {cmd_chain, cmd_opcode, cmd_a, cmd_b};
  assign {head_chain, head_op, head_a, head_b} = head;
  // rsp_y is the chain register: it resets to 0 and reloads at every capture edge.
  assign head_a_eff = head_chain ? rsp_y : head_a;
`else
  logic chain_unused;
  assign chain_unused = cmd_chain;
  assign push_data    = {cmd_opcode, cmd_a, cmd_b};
  assign {head_op, head_a, head_b} = head;
  assign head_a_eff   = head_a;
`endif

  alu_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Sequencer FSM with registered ALU drive, response capture and overflow counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      alu_a        <= '0;
      alu_b        <= '0;
      alu_opcode   <= '0;
      rsp_valid    <= 1'b0;
      rsp_y        <= '0;
      rsp_overflow <= 1'b0;
      rsp_opcode   <= '0;
      ovf_count    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            alu_a      <= head_a_eff;
            alu_b      <= head_b;
            alu_opcode <= head_op;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          rsp_y        <= alu_y;
          rsp_overflow <= alu_overflow;
          rsp_opcode   <= alu_opcode;
          rsp_valid    <= 1'b1;
          if (alu_overflow && (ovf_count != '1)) begin
            ovf_count <= ovf_count + 1'b1;
          end
          state <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            if (pop) begin
              alu_a      <= head_a_eff;
              alu_b      <= head_b;
              alu_opcode <= head_op;
              state      <= ISSUE;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer. A behavioural ALU stands in for
// the external datapath; a queue-based model predicts every response in order.
module tb_alu_cmd_sequencer;
  import alu_pkg::*;

  localparam int N          = 4;
  localparam int FIFO_DEPTH = 4;
  localparam logic [N-1:0] MAX_S = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] MIN_S = {1'b1, {(N-1){1'b0}}};

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [2:0]   cmd_opcode = '0;
  logic [N-1:0] cmd_a = '0;
  logic [N-1:0] cmd_b = '0;
  logic         cmd_chain = 1'b0;
  logic [N-1:0] alu_a;
  logic [N-1:0] alu_b;
  logic [2:0]   alu_opcode;
  logic [N-1:0] alu_y;
  logic         alu_overflow;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [N-1:0] rsp_y;
  logic         rsp_overflow;
  logic [2:0]   rsp_opcode;
  logic [7:0]   ovf_count;

  alu_cmd_sequencer #(.N(N), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_opcode   (cmd_opcode),
    .cmd_a        (cmd_a),
    .cmd_b        (cmd_b),
    .cmd_chain    (cmd_chain),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_opcode   (alu_opcode),
    .alu_y        (alu_y),
    .alu_overflow (alu_overflow),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_y        (rsp_y),
    .rsp_overflow (rsp_overflow),
    .rsp_opcode   (rsp_opcode),
    .ovf_count    (ovf_count)
  );

  initial forever #5 clk = ~clk;

  // Behavioural ALU: {overflow, y}. Carry/borrow for ADD/SUB, signed overflow for INC/DEC.
  function automatic logic [N:0] alu_fn(input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
    logic [N:0] r;
    case (op)
      3'd0: r = {1'b0, a} + {1'b0, b};
      3'd1: begin r = {1'b0, a} - {1'b0, b}; r[N] = (a < b); end
      3'd2: r = {(a == MIN_S), a - 1'b1};
      3'd3: r = {(a == MAX_S), a + 1'b1};
      3'd4: r = {1'b0, ~a};
      3'd5: r = {1'b0, a & b};
      3'd6: r = {1'b0, a | b};
      default: r = {1'b0, a ^ b};
    endcase
    return r;
  endfunction

  assign {alu_overflow, alu_y} = alu_fn(alu_opcode, alu_a, alu_b);

  typedef struct packed {
    logic [N-1:0] y;
    logic         ovf;
    logic [2:0]   op;
    logic [7:0]   cnt;
  } rsp_t;

  rsp_t exp_q[$];
  rsp_t got_q[$];
  rsp_t want_q[$];
  int   push_edge_q[$];
  int   obs_edge_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  logic [N-1:0] m_last_y = '0;
  int   m_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Model and observer: commands accepted before an edge are predicted in
  // order; each response handshake is paired with the oldest prediction.
  always @(negedge clk) begin
    rsp_t       e;
    rsp_t       w;
    rsp_t       g;
    logic [N:0] r;
    logic [N-1:0] a_eff;
    if (rst) begin
      exp_q.delete();
      got_q.delete();
      want_q.delete();
      push_edge_q.delete();
      obs_edge_q.delete();
      m_last_y = '0;
      m_cnt    = 0;
    end else begin
      if (cmd_valid && cmd_ready) begin
        a_eff = cmd_a;
`ifdef ALU_CHAIN_EN
        if (cmd_chain) a_eff = m_last_y;
`endif
        r        = alu_fn(cmd_opcode, a_eff, cmd_b);
        m_last_y = r[N-1:0];
        e.y   = r[N-1:0];
        e.ovf = r[N];
        e.op  = cmd_opcode;
        e.cnt = '0;
        exp_q.push_back(e);
        push_edge_q.push_back(cyc + 1);
      end
      if (rsp_valid && rsp_ready) begin
        g.y   = rsp_y;
        g.ovf = rsp_overflow;
        g.op  = rsp_opcode;
        g.cnt = ovf_count;
        if (exp_q.size() > 0) begin
          w = exp_q.pop_front();
          if (w.ovf && m_cnt < 255) m_cnt++;
          w.cnt = 8'(m_cnt);
        end else begin
          w = 'x;
        end
        got_q.push_back(g);
        want_q.push_back(w);
        obs_edge_q.push_back(cyc);
      end
    end
  end

  task automatic send(input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b, input logic ch);
    cmd_opcode = op;
    cmd_a      = a;
    cmd_b      = b;
    cmd_chain  = ch;
    cmd_valid  = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        return;
      end
    end
    checks++; failures++;
    $display("FAIL send_timeout cmd_ready=%b want=1", cmd_ready);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_got(input int n, input string name);
    for (int i = 0; i < 3000 && got_q.size() < n; i++) @(negedge clk);
    if (got_q.size() < n) begin
      checks++; failures++;
      $display("FAIL %s_timeout responses=%0d want=%0d", name, got_q.size(), n);
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; cmd_valid = 1'b1; cmd_opcode = 3'd0; cmd_a = 4'h3; cmd_b = 4'h4; rsp_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b0) begin failures++; $display("FAIL reset_cmd_ready got=%b want=0", cmd_ready); end
    checks++;
    if ({alu_a, alu_b, alu_opcode, rsp_valid, rsp_y, rsp_overflow, rsp_opcode, ovf_count} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got a=%h b=%h op=%0d v=%b y=%h o=%b rop=%0d cnt=%0d want all 0",
               alu_a, alu_b, alu_opcode, rsp_valid, rsp_y, rsp_overflow, rsp_opcode, ovf_count);
    end
    @(posedge clk); #1;
    rst = 1'b0; cmd_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_release_ready got=%b want=1", cmd_ready); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_no_push cycle=%0d rsp_valid=%b want=0", i, rsp_valid); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic_add;
    do_reset;
    rsp_ready = 1'b1;
    send(ADD, 4'h9, 4'h8, 1'b0);
    wait_got(1, "basic");
    checks++;
    if (got_q[0].y !== 4'h1 || got_q[0].ovf !== 1'b1 || got_q[0].op !== 3'd0 || got_q[0].cnt !== 8'd1) begin
      failures++;
      $display("FAIL basic_add got y=%h ovf=%b op=%0d cnt=%0d want y=1 ovf=1 op=0 cnt=1",
               got_q[0].y, got_q[0].ovf, got_q[0].op, got_q[0].cnt);
    end
    checks++;
    if (obs_edge_q[0] - push_edge_q[0] !== 2) begin
      failures++; $display("FAIL basic_latency got=%0d want=2", obs_edge_q[0] - push_edge_q[0]);
    end
  endtask

  task automatic test_sub_inc;
    do_reset;
    rsp_ready = 1'b1;
    send(SUB, 4'h3, 4'h5, 1'b0);
    send(INC, 4'hF, 4'h0, 1'b0);
    wait_got(2, "sub_inc");
    checks++;
    if (got_q[0].y !== 4'hE || got_q[0].ovf !== 1'b1 || got_q[0].op !== 3'd1) begin
      failures++; $display("FAIL sub_borrow got y=%h ovf=%b op=%0d want y=e ovf=1 op=1", got_q[0].y, got_q[0].ovf, got_q[0].op);
    end
    checks++;
    if (got_q[1].y !== 4'h0 || got_q[1].ovf !== 1'b0 || got_q[1].op !== 3'd3 || got_q[1].cnt !== 8'd1) begin
      failures++; $display("FAIL inc_wrap got y=%h ovf=%b op=%0d cnt=%0d want y=0 ovf=0 op=3 cnt=1",
                           got_q[1].y, got_q[1].ovf, got_q[1].op, got_q[1].cnt);
    end
  endtask

  task automatic test_backpressure;
    do_reset;
    rsp_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cmd_valid  = 1'b1;
      cmd_opcode = 3'($urandom_range(0, 7));
      cmd_a      = N'($urandom);
      cmd_b      = N'($urandom);
      cmd_chain  = 1'($urandom);
      @(posedge clk); #1;
    end
    checks++;
    if (exp_q.size() !== 5) begin failures++; $display("FAIL bp_accepted got=%0d want=5", exp_q.size()); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (cmd_ready !== 1'b0) begin failures++; $display("FAIL bp_full_ready cycle=%0d got=%b want=0", i, cmd_ready); end
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    wait_got(5, "bp");
    checks++;
    if (got_q.size() !== 5) begin failures++; $display("FAIL bp_count got=%0d want=5", got_q.size()); end
    for (int i = 0; i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== want_q[i]) begin
        failures++;
        $display("FAIL bp_rsp[%0d] got y=%h ovf=%b op=%0d cnt=%0d want y=%h ovf=%b op=%0d cnt=%0d", i,
                 got_q[i].y, got_q[i].ovf, got_q[i].op, got_q[i].cnt, want_q[i].y, want_q[i].ovf, want_q[i].op, want_q[i].cnt);
      end
    end
    for (int i = 1; i < obs_edge_q.size(); i++) begin
      checks++;
      if (obs_edge_q[i] - obs_edge_q[i-1] !== 2) begin
        failures++; $display("FAIL bp_spacing[%0d] got=%0d want=2", i, obs_edge_q[i] - obs_edge_q[i-1]);
      end
    end
  endtask

  task automatic test_stability;
    logic [2:0]   op0;
    logic [N-1:0] a0;
    logic [N-1:0] b0;
    do_reset;
    rsp_ready = 1'b0;
    op0 = 3'($urandom_range(0, 7));
    a0  = N'($urandom);
    b0  = N'($urandom);
    send(op0, a0, b0, 1'b0);
    send(3'($urandom_range(0, 7)), N'($urandom), N'($urandom), 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid) break;
    end
    checks++;
    if (rsp_valid !== 1'b1) begin failures++; $display("FAIL stab_valid got=%b want=1", rsp_valid); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_y !== exp_q[0].y || rsp_overflow !== exp_q[0].ovf || rsp_opcode !== exp_q[0].op ||
          alu_a !== a0 || alu_b !== b0 || alu_opcode !== op0) begin
        failures++;
        $display("FAIL stab_hold cycle=%0d got v=%b y=%h o=%b op=%0d a=%h b=%h aop=%0d want v=1 y=%h o=%b op=%0d a=%h b=%h aop=%0d",
                 i, rsp_valid, rsp_y, rsp_overflow, rsp_opcode, alu_a, alu_b, alu_opcode,
                 exp_q[0].y, exp_q[0].ovf, exp_q[0].op, a0, b0, op0);
      end
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    wait_got(2, "stab");
    for (int i = 0; i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== want_q[i]) begin
        failures++;
        $display("FAIL stab_rsp[%0d] got y=%h ovf=%b op=%0d cnt=%0d want y=%h ovf=%b op=%0d cnt=%0d", i,
                 got_q[i].y, got_q[i].ovf, got_q[i].op, got_q[i].cnt, want_q[i].y, want_q[i].ovf, want_q[i].op, want_q[i].cnt);
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [2:0]   co [5];
    logic [N-1:0] ca [5];
    logic [N-1:0] cb [5];
    do_reset;
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      co[i] = 3'($urandom_range(0, 7));
      ca[i] = N'($urandom);
      cb[i] = N'($urandom);
      send(co[i], ca[i], cb[i], 1'b0);
    end
    rsp_ready = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (got_q.size() !== 1 || got_q[0] !== want_q[0]) begin
      failures++;
      $display("FAIL mid_first_rsp got n=%0d y=%h ovf=%b op=%0d want n=1 y=%h ovf=%b op=%0d",
               got_q.size(), got_q[0].y, got_q[0].ovf, got_q[0].op, want_q[0].y, want_q[0].ovf, want_q[0].op);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || alu_a !== ca[1] || alu_b !== cb[1] || alu_opcode !== co[1] || cmd_ready !== 1'b0) begin
      failures++;
      $display("FAIL mid_issue got v=%b a=%h b=%h op=%0d rdy=%b want v=0 a=%h b=%h op=%0d rdy=0",
               rsp_valid, alu_a, alu_b, alu_opcode, cmd_ready, ca[1], cb[1], co[1]);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({alu_a, alu_b, alu_opcode, rsp_valid, rsp_y, rsp_overflow, rsp_opcode, ovf_count} !== '0 || cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL mid_after_reset got a=%h b=%h op=%0d v=%b y=%h o=%b rop=%0d cnt=%0d rdy=%b want all 0 rdy=1",
               alu_a, alu_b, alu_opcode, rsp_valid, rsp_y, rsp_overflow, rsp_opcode, ovf_count, cmd_ready);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0) begin failures++; $display("FAIL mid_dropped cycle=%0d rsp_valid=%b want=0", i, rsp_valid); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_chain;
    logic [N-1:0] want_y;
    logic         want_o;
`ifdef ALU_CHAIN_EN
    want_y = 4'h9; want_o = 1'b0;
`else
    want_y = 4'h3; want_o = 1'b1;
`endif
    do_reset;
    rsp_ready = 1'b1;
    send(ADD, 4'h2, 4'h3, 1'b0);
    send(ADD, 4'hF, 4'h4, 1'b1);
    wait_got(2, "chain");
    checks++;
    if (got_q[0].y !== 4'h5 || got_q[1].y !== want_y || got_q[1].ovf !== want_o) begin
      failures++;
      $display("FAIL chain got y0=%h y1=%h ovf1=%b want y0=5 y1=%h ovf1=%b", got_q[0].y, got_q[1].y, got_q[1].ovf, want_y, want_o);
    end
  endtask

  task automatic test_random_stream;
    do_reset;
    fork
      begin
        for (int i = 0; i < 40; i++) send(3'($urandom_range(0, 7)), N'($urandom), N'($urandom), 1'($urandom));
      end
      begin
        for (int j = 0; j < 4000 && got_q.size() < 40; j++) begin
          rsp_ready = 1'($urandom_range(0, 1));
          @(posedge clk); #1;
        end
      end
    join
    checks++;
    if (got_q.size() !== 40) begin failures++; $display("FAIL rand_count got=%0d want=40", got_q.size()); end
    for (int i = 0; i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== want_q[i]) begin
        failures++;
        $display("FAIL rand_rsp[%0d] got y=%h ovf=%b op=%0d cnt=%0d want y=%h ovf=%b op=%0d cnt=%0d", i,
                 got_q[i].y, got_q[i].ovf, got_q[i].op, got_q[i].cnt, want_q[i].y, want_q[i].ovf, want_q[i].op, want_q[i].cnt);
      end
    end
  endtask

  task automatic test_ovf_saturate;
    do_reset;
    rsp_ready = 1'b1;
    for (int i = 0; i < 260; i++) send(ADD, 4'hF, 4'hF, 1'b0);
    wait_got(260, "sat");
    checks++;
    if (got_q[253].cnt !== 8'd254 || got_q[254].cnt !== 8'd255 || got_q[259].cnt !== 8'd255 || ovf_count !== 8'hFF) begin
      failures++;
      $display("FAIL ovf_saturate got c253=%0d c254=%0d c259=%0d final=%0d want 254 255 255 255",
               got_q[253].cnt, got_q[254].cnt, got_q[259].cnt, ovf_count);
    end
    for (int i = 0; i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== want_q[i]) begin
        failures++;
        $display("FAIL sat_rsp[%0d] got y=%h ovf=%b cnt=%0d want y=%h ovf=%b cnt=%0d", i,
                 got_q[i].y, got_q[i].ovf, got_q[i].cnt, want_q[i].y, want_q[i].ovf, want_q[i].cnt);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_basic_add;
    test_sub_inc;
    test_backpressure;
    test_stability;
    test_reset_mid;
    test_chain;
    test_random_stream;
    test_ovf_saturate;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
